neuron_layer_ctrl: RTL

NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

---
 rtl/nn_ctrl_pkg.sv | 51 +++++
 rtl/mod_counter.sv | 25 ++
 rtl/neuron_layer_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared types for the neuron-layer controller:
// FSM state encoding and the control-output bundle.
package nn_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLR   = 3'd1;
   localparam logic [2:0] ST_FETCH = 3'd2;
   localparam logic [2:0] ST_MAC   = 3'd3;
   localparam logic [2:0] ST_ACT   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      CLR   = ST_CLR,
      FETCH = ST_FETCH,
      MAC   = ST_MAC,
      ACT   = ST_ACT,
      DONE  = ST_DONE
   } state_t;

   typedef struct packed {
      logic clr_acc;
      logic ld_x;
      logic ld_w;
      logic ld_acc;
      logic ld_out;
      logic busy;
      logic done;
   } ctrl_t;

   // Pure state decode; outputs never see start directly.
   function automatic ctrl_t decode(state_t s);
      ctrl_t c;
      c = '0;
      unique case (s)
         IDLE:  c = '0;
         CLR:   begin c.clr_acc = 1'b1; c.busy = 1'b1; end
         FETCH: begin
            c.ld_x = 1'b1;
            c.ld_w = 1'b1;
            c.busy = 1'b1;
         end
         MAC:   begin c.ld_acc = 1'b1; c.busy = 1'b1; end
         ACT:   begin c.ld_out = 1'b1; c.busy = 1'b1; end
         DONE:  begin c.done = 1'b1; c.busy = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at MAX so an index can never wrap.
module mod_counter #(
   parameter int WIDTH = 2,
   parameter int MAX   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q,
   output logic             last
);

   assign last = (q == WIDTH'(MAX));

   // Count register: clear wins over increment, stop at MAX.
   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (inc && !last)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully-connected layer: per neuron,
// clear acc, NUM_IN fetch/MAC pairs, then write output.
module neuron_layer_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int NUM_IN  = 4,
   parameter int NUM_NEU = 3,
   parameter int XAW     = 2,
   parameter int WAW     = 4,
   parameter int NAW     = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [XAW-1:0] x_addr,
   output logic [WAW-1:0] w_addr,
   output logic [NAW-1:0] n_idx,
   output logic           ld_x,
   output logic           ld_w,
   output logic           clr_acc,
   output logic           ld_acc,
   output logic           ld_out,
   output logic           busy,
   output logic           done
);

   state_t         state;
   state_t         nxt;
   ctrl_t          ctl;
   logic [XAW-1:0] i_q;
   logic [NAW-1:0] n_q;
   logic           i_last;
   logic           n_last;
   logic           i_clr;
   logic           n_clr;
   logic           n_inc;
   logic [WAW-1:0] base;

   // New run begins; next neuron begins.
   assign n_clr = (state == IDLE) && start;
   assign n_inc = (state == ACT) && !n_last;
   assign i_clr = n_clr || n_inc;

   mod_counter #(
      .WIDTH (XAW),
      .MAX   (NUM_IN - 1)
   ) u_cnt_i (
      .clk  (clk),
      .rst  (rst),
      .clr  (i_clr),
      .inc  (state == MAC),
      .q    (i_q),
      .last (i_last)
   );

   mod_counter #(
      .WIDTH (NAW),
      .MAX   (NUM_NEU - 1)
   ) u_cnt_n (
      .clk  (clk),
      .rst  (rst),
      .clr  (n_clr),
      .inc  (n_inc),
      .q    (n_q),
      .last (n_last)
   );

   // Running weight base n*NUM_IN, built by addition only.
   always_ff @(posedge clk) begin
      if (rst || n_clr)
         base <= '0;
      else if (n_inc)
         base <= base + WAW'(NUM_IN);
   end

   // State register; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   // Next-state logic.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  nxt = start ? CLR : IDLE;
         CLR:   nxt = FETCH;
         FETCH: nxt = MAC;
         MAC:   nxt = i_last ? ACT : FETCH;
         ACT:   nxt = n_last ? DONE : CLR;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      ctl = decode(state);
   end

   assign clr_acc = ctl.clr_acc;
   assign ld_x    = ctl.ld_x;
   assign ld_w    = ctl.ld_w;
   assign ld_acc  = ctl.ld_acc;
   assign ld_out  = ctl.ld_out;
   assign busy    = ctl.busy;
   assign done    = ctl.done;

   assign x_addr = i_q;
   assign w_addr = base + WAW'(i_q);
   assign n_idx  = n_q;

endmodule
